// File: rtl/result_reporter_pkg.sv
// result_reporter_pkg: FSM state encoding and ASCII byte constants
// shared by result_reporter and its bench.
package result_reporter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      SKIP,
      SEND_DIG,
      SEND_CR,
      SEND_LF,
      SEND_ERR
   } state_t;

   localparam logic [7:0] ASC_ZERO = 8'h30;
   localparam logic [7:0] ASC_CR   = 8'h0D;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_E    = 8'h45;
   localparam logic [7:0] ASC_R    = 8'h52;

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: serial double-dabble, one bit per cycle for RESULT_W cycles.
// Ports: start/value capture, busy while shifting, done on the last shift,
// bcd holds NDIG digits (LS digit in bits 3:0) until the next start.
module bin2bcd #(
   parameter int RESULT_W = 40,
   parameter int NDIG     = 13
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [RESULT_W-1:0]   value,
   output logic                  busy,
   output logic                  done,
   output logic [4*NDIG-1:0]     bcd
);

   localparam int CW = $clog2(RESULT_W + 1);

   logic [RESULT_W-1:0] bin_q;
   logic [CW-1:0]       cnt_q;
   logic [4*NDIG-1:0]   adj;

   // add-3 to every digit >= 5 before the shift
   always_comb begin
      adj = bcd;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd   <= '0;
         cnt_q <= '0;
      end else if (start) begin
         bin_q <= value;
         bcd   <= '0;
         cnt_q <= CW'(RESULT_W);
      end else if (cnt_q != '0) begin
         bcd   <= {adj[4*NDIG-2:0], bin_q[RESULT_W-1]};
         bin_q <= {bin_q[RESULT_W-2:0], 1'b0};
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign busy = (cnt_q != '0);
   assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/result_reporter.sv
// result_reporter: prints the solver result as decimal ASCII + CR LF,
// or "ERR" CR LF on error, over a valid/ready byte stream.
// Ports: clk, rst_n, result/done/error from solver,
// tx_data/tx_valid/tx_ready byte sink, busy, report_done pulse.
module result_reporter
   import result_reporter_pkg::*;
#(
   parameter int RESULT_W = 40,
   parameter int NDIG     = 13
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [RESULT_W-1:0] result,
   input  logic                done,
   input  logic                error,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic                report_done
);

   localparam int IW = $clog2(NDIG);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [1:0]      ecnt_q, ecnt_d;
   logic            rdone_q, rdone_d;
   logic            done_q, error_q;
   logic            done_rise, err_rise;
   logic            cv_start, cv_busy, cv_done;
   logic [4*NDIG-1:0] bcd;
   logic [3:0]      digit;

   bin2bcd #(
      .RESULT_W (RESULT_W),
      .NDIG     (NDIG)
   ) u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (cv_start),
      .value (result),
      .busy  (cv_busy),
      .done  (cv_done),
      .bcd   (bcd)
   );

   assign done_rise = done & ~done_q;
   assign err_rise  = error & ~error_q;
   assign digit     = bcd[4*int'(idx_q) +: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ecnt_q  <= '0;
         rdone_q <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ecnt_q  <= ecnt_d;
         rdone_q <= rdone_d;
         done_q  <= done;
         error_q <= error;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ecnt_d   = ecnt_q;
      rdone_d  = 1'b0;
      cv_start = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      unique case (state_q)
         IDLE: begin
            // error wins a same-cycle tie with done
            if (err_rise) begin
               state_d = SEND_ERR;
               ecnt_d  = '0;
            end else if (done_rise) begin
               cv_start = 1'b1;
               state_d  = CONV;
            end
         end
         CONV: begin
            if (cv_done || !cv_busy) begin
               state_d = SKIP;
               idx_d   = IW'(NDIG - 1);
            end
         end
         SKIP: begin
            if (idx_q != '0 && digit == 4'd0) begin
               idx_d = idx_q - IW'(1);
            end else begin
               state_d = SEND_DIG;
            end
         end
         SEND_DIG: begin
            tx_valid = 1'b1;
            tx_data  = ASC_ZERO + {4'h0, digit};
            if (tx_ready) begin
               if (idx_q == '0) begin
                  state_d = SEND_CR;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end
         end
         SEND_ERR: begin
            tx_valid = 1'b1;
            tx_data  = (ecnt_q == 2'd0) ? ASC_E : ASC_R;
            if (tx_ready) begin
               if (ecnt_q == 2'd2) begin
                  state_d = SEND_CR;
               end else begin
                  ecnt_d = ecnt_q + 2'd1;
               end
            end
         end
         SEND_CR: begin
            tx_valid = 1'b1;
            tx_data  = ASC_CR;
            if (tx_ready) state_d = SEND_LF;
         end
         SEND_LF: begin
            tx_valid = 1'b1;
            tx_data  = ASC_LF;
            if (tx_ready) begin
               state_d = IDLE;
               rdone_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign report_done = rdone_q;

endmodule

// File: tb/tb_result_reporter.sv
// tb_result_reporter: randomized scoreboard bench for result_reporter;
// decimal reference model feeds a byte queue checked by a monitor.
module tb_result_reporter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [39:0] result;
   logic        done;
   logic        error;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        report_done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int xfers = 0;
   int rdone_cnt = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   bit rand_ready = 1'b0;
   bit pend_valid = 1'b0;
   logic [7:0] pend_data;
   logic [7:0] exp_q[$];

   result_reporter #(
      .RESULT_W (40),
      .NDIG     (13)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .result      (result),
      .done        (done),
      .error       (error),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .report_done (report_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // monitor: sample mid-cycle, transfer happens at the following edge
   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst_n) begin
         pend_valid = 1'b0;
      end else begin
         if (pend_valid) begin
            tests++;
            if (!(tx_valid && tx_data == pend_data)) begin
               fails++;
               $display("FAIL stable: valid=%0b data=%02h required data=%02h",
                        tx_valid, tx_data, pend_data);
            end
         end
         pend_valid = tx_valid && !tx_ready;
         pend_data  = tx_data;
         if (tx_valid && tx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL byte: got %02h, required none", tx_data);
            end else begin
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  fails++;
                  $display("FAIL byte: got %02h, required %02h", tx_data, e);
               end
            end
            if (xfers == 0) first_cyc = cyc;
            last_cyc = cyc;
            xfers++;
         end
         if (report_done) rdone_cnt++;
      end
   end

   function automatic void push_num(input logic [39:0] v);
      logic [7:0] d[$];
      longint unsigned x;
      x = 64'(v);
      do begin
         d.push_front(8'h30 + 8'(x % 10));
         x = x / 10;
      end while (x != 0);
      foreach (d[i]) exp_q.push_back(d[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   function automatic void push_err();
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h52);
      exp_q.push_back(8'h52);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   task automatic check(input string name, input longint act,
                        input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic report(input logic [39:0] v, input logic de,
                         input logic ee, input bit hold);
      int base;
      int n;
      @(posedge clk);
      #1;
      result = v;
      if (ee) push_err();
      else push_num(v);
      xfers = 0;
      base = rdone_cnt;
      check("idle_busy", busy, 0);
      done = de;
      error = ee;
      @(posedge clk);
      #1;
      check("busy_rise", busy, 1);
      n = 0;
      while (rdone_cnt == base && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (n >= 400) begin
         tests++;
         fails++;
         $display("FAIL timeout: no report_done after %0d cycles", n);
      end
      repeat (3) @(posedge clk);
      check("rdone_pulses", rdone_cnt, base + 1);
      check("queue_empty", exp_q.size(), 0);
      check("busy_after", busy, 0);
      if (!hold) begin
         #1;
         done = 1'b0;
         error = 1'b0;
         repeat (2) @(posedge clk);
      end
   endtask

   initial begin
      logic [39:0] v;
      int n;
      int bits;
      rst_n = 1'b0;
      done = 1'b0;
      error = 1'b0;
      result = '0;
      #12;
      check("rst_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", tx_data, 0);
      check("rst_rdone", report_done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      report(40'd5537376230, 1'b1, 1'b0, 1'b0);
      check("nbytes", xfers, 12);
      check("back_to_back", last_cyc - first_cyc + 1, 12);

      report(40'd0, 1'b1, 1'b0, 1'b0);
      check("zero_bytes", xfers, 3);
      report(40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
      check("max_bytes", xfers, 15);
      check("max_b2b", last_cyc - first_cyc + 1, 15);

      report(40'd123, 1'b0, 1'b1, 1'b0);
      check("err_bytes", xfers, 5);
      report(40'd987, 1'b1, 1'b1, 1'b0);
      check("err_tie_bytes", xfers, 5);

      rand_ready = 1'b1;
      report(40'd5537376230, 1'b1, 1'b0, 1'b0);
      report(40'd0, 1'b1, 1'b1, 1'b0);
      rand_ready = 1'b0;

      report(40'd42, 1'b1, 1'b0, 1'b1);
      n = rdone_cnt;
      repeat (500) @(posedge clk);
      check("hold_no_retrig", rdone_cnt, n);
      check("hold_no_bytes", exp_q.size(), 0);
      #1;
      done = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 16; i++) begin
         bits = $urandom_range(1, 40);
         v = {8'($urandom), 32'($urandom)};
         v = v & ((40'd1 << bits) - 40'd1);
         rand_ready = (i % 2) == 1;
         if ($urandom_range(0, 5) == 0) report(v, 1'b0, 1'b1, 1'b0);
         else report(v, 1'b1, 1'b0, 1'b0);
      end
      rand_ready = 1'b0;

      // abandon a report while its 4th digit is on offer
      @(posedge clk);
      #1;
      result = 40'd5537376230;
      push_num(result);
      xfers = 0;
      done = 1'b1;
      n = 0;
      while (xfers < 3 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("pre_rst_xfers", xfers, 3);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", tx_data, 0);
      check("mid_rst_rdone", report_done, 0);
      exp_q.delete();
      done = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      check("post_rst_idle", busy, 0);
      report(40'd5537376230, 1'b1, 1'b0, 1'b0);
      check("post_rst_bytes", xfers, 12);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
